lookahead_addsub_pipe: RTL

Parametrised, pipelined add/subtract unit built from 4-bit carry/borrow-lookahead groups, one group per pipeline stage, with carry/borrow rippling between stages through registers. It is the datapath-width successor of our 4-bit borrow-lookahead subtractor: any multiple-of-4 width, add or subtract per transaction, signed-overflow and zero flags, and a valid/ready stream interface so it can sit between the operand register file and the result writeback stage.

---
 rtl/lookahead_pkg.sv | 16 +
 rtl/lookahead_group4.sv | 53 +++++
 rtl/lookahead_addsub_pipe.sv | 127 ++++++++++++
 3 files changed

// File: rtl/lookahead_pkg.sv
// Shared constants and helpers for the pipelined lookahead add/subtract unit.
//   GROUP_W    : bits handled per lookahead group (and per pipeline stage)
//   OP_ADD/SUB : encoding of the op input
//   num_groups : number of groups, which is also the latency in cycles
package lookahead_pkg;

  localparam int unsigned GROUP_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int unsigned num_groups(input int unsigned width);
    return width / GROUP_W;
  endfunction

endpackage

// File: rtl/lookahead_group4.sv
// Combinational 4-bit carry/borrow-lookahead group.
//   op    : OP_ADD -> x4 + y4 + cin, OP_SUB -> x4 - y4 - cin
//   x4/y4 : operand nibbles
//   cin   : carry-in (add) or borrow-in (sub)
//   s4    : result nibble
//   cout  : carry/borrow out of bit 3
//   c_msb : carry/borrow into bit 3 (used for signed overflow)
module lookahead_group4
  import lookahead_pkg::*;
(
  input  logic               op,
  input  logic [GROUP_W-1:0] x4,
  input  logic [GROUP_W-1:0] y4,
  input  logic               cin,
  output logic [GROUP_W-1:0] s4,
  output logic               cout,
  output logic               c_msb
);

  logic [GROUP_W-1:0] p;
  logic [GROUP_W-1:0] g;
  logic [GROUP_W:0]   c;

  // Borrow generate/propagate for subtract, carry generate/propagate for add.
  always_comb begin
    p = x4 ^ y4;
    g = x4 & y4;
    case (op)
      OP_ADD: ;
      OP_SUB: begin
        p = ~(x4 ^ y4);
        g = ~x4 & y4;
      end
      default: ;
    endcase
  end

  // Fully expanded lookahead: every chain bit is two levels from g/p/cin.
  always_comb begin
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
  end

  // x ^ y ^ chain gives the sum for add and the difference for subtract.
  assign s4    = x4 ^ y4 ^ c[GROUP_W-1:0];
  assign cout  = c[GROUP_W];
  assign c_msb = c[GROUP_W-1];

endmodule

// File: rtl/lookahead_addsub_pipe.sv
// Pipelined add/subtract unit, one 4-bit lookahead group per stage, with the
// carry/borrow passed between stages through registers. Latency = WIDTH/4.
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : operand handshake (in_ready is combinational)
//   op, x, y, cbin       : operation, operands, carry/borrow in
//   out_valid / out_ready: result handshake
//   d, cbout, ovf, zero  : registered result and flags
module lookahead_addsub_pipe
  import lookahead_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cbin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             cbout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NG = num_groups(WIDTH);

  if ((WIDTH % GROUP_W) != 0 || WIDTH < GROUP_W) begin : g_width_check
    $fatal(1, "lookahead_addsub_pipe: WIDTH must be a multiple of 4 and at least 4");
  end

  // Stage k holds a transaction whose groups 0..k-1 are already resolved.
  logic [NG-1:0]      v_q;
  logic [NG-1:0]      op_q;
  logic [NG-1:0]      c_q;
  logic [WIDTH-1:0]   x_q   [NG];
  logic [WIDTH-1:0]   y_q   [NG];
  logic [WIDTH-1:0]   r_q   [NG];
  logic [WIDTH-1:0]   r_c   [NG];
  logic [GROUP_W-1:0] s4_c  [NG];
  logic [NG-1:0]      cout_c;
  logic [NG-1:0]      cmsb_c;
  logic               unused_cmsb_c;
  logic               en_c;

  logic               out_valid_q;
  logic [WIDTH-1:0]   d_q;
  logic               cbout_q;
  logic               ovf_q;
  logic               zero_q;

  // The whole pipe, bubbles included, advances only when the output slot frees.
  assign en_c     = !out_valid_q || out_ready;
  assign in_ready = en_c;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    lookahead_group4 u_grp (
      .op    (op_q[k]),
      .x4    (x_q[k][GROUP_W*k +: GROUP_W]),
      .y4    (y_q[k][GROUP_W*k +: GROUP_W]),
      .cin   (c_q[k]),
      .s4    (s4_c[k]),
      .cout  (cout_c[k]),
      .c_msb (cmsb_c[k])
    );
  end

  // Only the last group's carry-into-MSB feeds the overflow flag.
  assign unused_cmsb_c = ^cmsb_c;

  // Merge each stage's freshly computed nibble into the travelling result.
  always_comb begin
    for (int k = 0; k < NG; k++) begin
      r_c[k] = r_q[k];
      r_c[k][GROUP_W*k +: GROUP_W] = s4_c[k];
    end
  end

  // Stage registers, valid chain and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= '0;
      op_q <= '0;
      c_q  <= '0;
      for (int k = 0; k < NG; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
        r_q[k] <= '0;
      end
      out_valid_q <= 1'b0;
      d_q         <= '0;
      cbout_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (en_c) begin
      v_q[0]  <= in_valid;
      op_q[0] <= op;
      c_q[0]  <= cbin;
      x_q[0]  <= x;
      y_q[0]  <= y;
      r_q[0]  <= '0;
      for (int k = 1; k < NG; k++) begin
        v_q[k]  <= v_q[k-1];
        op_q[k] <= op_q[k-1];
        c_q[k]  <= cout_c[k-1];
        x_q[k]  <= x_q[k-1];
        y_q[k]  <= y_q[k-1];
        r_q[k]  <= r_c[k-1];
      end
      out_valid_q <= v_q[NG-1];
      d_q         <= r_c[NG-1];
      cbout_q     <= cout_c[NG-1];
      ovf_q       <= cmsb_c[NG-1] ^ cout_c[NG-1];
      zero_q      <= ~|r_c[NG-1];
    end
  end

  assign out_valid = out_valid_q;
  assign d         = d_q;
  assign cbout     = cbout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
